// File: rtl/fp_pkg.sv
// Shared constants and types for the four-phase dual-rail receiver.
package fp_pkg;

    localparam int RAIL_NUM = 2;

    localparam logic [1:0] FP_NULL = 2'b00;
    localparam logic [1:0] FP_F    = 2'b01;
    localparam logic [1:0] FP_T    = 2'b10;
    localparam logic [1:0] FP_ILL  = 2'b11;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } fp_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop synchroniser for asynchronous rails, synchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/fp_rx_clk.sv
// Clocked consumer for a four-phase dual-rail link with a small output FIFO.
// Optional illegal-code detection is built when FP_RX_ERR_EN is defined.
module fp_rx_clk #(
    parameter int WIDTH    = 8,
    parameter int RAIL_NUM = 2,
    parameter int DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]   in,
    output logic                             ack_o,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             err
);

    import fp_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH*RAIL_NUM-1:0]           w_inFlat;
    logic [WIDTH*RAIL_NUM-1:0]           w_inSyncFlat;
    logic [WIDTH-1:0][RAIL_NUM-1:0]      w_inS;
    logic                                w_complete;
    logic                                w_isNull;
    logic [WIDTH-1:0]                    w_word;
    logic                                w_full;
    logic                                w_push;
    logic                                w_pop;

    fp_rx_state_t                        r_state;
    logic                                r_ack;
    logic [WIDTH-1:0]                    r_mem [DEPTH];
    logic [AW-1:0]                       r_wrPtr;
    logic [AW-1:0]                       r_rdPtr;
    logic [AW:0]                         r_count;

    assign w_inFlat = in;

    sync_2ff #(
        .WIDTH (WIDTH*RAIL_NUM)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_inFlat),
        .o_q   (w_inSyncFlat)
    );

    assign w_inS = w_inSyncFlat;

`ifdef FP_RX_ERR_EN
    logic w_illegal;
`endif

    always_comb begin
        w_complete = 1'b1;
        w_isNull   = 1'b1;
        w_word     = '0;
`ifdef FP_RX_ERR_EN
        w_illegal  = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            if (w_inS[i] == FP_NULL) w_complete = 1'b0;
            else                     w_isNull   = 1'b0;
            w_word[i] = w_inS[i][1];
`ifdef FP_RX_ERR_EN
            if (w_inS[i] == FP_ILL) w_illegal = 1'b1;
`endif
        end
    end

    assign w_full = (r_count == FULL_CNT);
    // A same-cycle pop never frees space for the push; only full gates it.
    assign w_push = (r_state == WAIT_DATA) && w_complete && !w_full;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= WAIT_DATA;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                WAIT_DATA: begin
                    if (w_push) begin
                        r_ack   <= 1'b1;
                        r_state <= WAIT_NULL;
                    end
                end
                WAIT_NULL: begin
                    if (w_isNull) begin
                        r_ack   <= 1'b0;
                        r_state <= WAIT_DATA;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= WAIT_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ack_o     = r_ack;
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rdPtr];

`ifdef FP_RX_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n)                                   r_err <= 1'b0;
        else if ((r_state == WAIT_DATA) && w_illegal) r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/fp_rx_clk.md
# fp_rx_clk

Clocked receiver for a four-phase, dual-rail (FP) link. It sits directly downstream of the clockless dual-rail counter stage and acts as the link's consumer. It synchronises the asynchronous rails into `clk`, detects data and null wavefronts, and drives the return acknowledge. Decoded words are buffered in a small FIFO behind a valid/ready interface for synchronous logic.

## Interface
- `WIDTH`, 8, data bits per token.
- `RAIL_NUM`, 2, rails per bit; only 2 is supported.
- `DEPTH`, 4, FIFO entries; must be a power of 2 and ≥2.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; one clock; synchronous, active-low.
- `in`  in  [WIDTH-1:0][RAIL_NUM-1:0]  dual-rail bus from the async sender; asynchronous to `clk`.
- `ack_o`  out  1  four-phase acknowledge to the sender; registered.
- `out_data`  out  WIDTH  head-of-FIFO decoded word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer pop; a pop occurs when `out_valid && out_ready`.
- `err`  out  1  sticky illegal-code flag; see Configuration.

## Operation
- Rail code per bit `in[i]`:
  - 2'b00 = null.
  - 2'b01 = logic 0 (false rail).
  - 2'b10 = logic 1 (true rail).
  - 2'b11 = illegal.
- Every rail passes through a 2-flop synchroniser. All decisions use the synchronised copy `in_s`.
- `complete` = every bit of `in_s` non-null.
- `is_null` = every bit of `in_s` == 2'b00.
- Decoded word: bit i = `in_s[i][1]`.
- FSM, two states:
  - WAIT_DATA (reset state): if `complete && !full`, write the decoded word to the FIFO, set `ack_o`=1, go to WAIT_NULL. If `complete && full`, hold with `ack_o`=0; this stalls the sender.
  - WAIT_NULL: if `is_null`, set `ack_o`=0 and go to WAIT_DATA. Otherwise hold.
  - A partial wavefront (some bits null, some valid) never triggers a transition in either state.
- FIFO: circular buffer with read/write pointers and a count of width clog2(DEPTH)+1.
  - `full` = count==DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Push is gated only by `full`. A pop in the same cycle does not free space for a push.
  - `out_data` is valid only while `out_valid`=1. Its value is don't-care when empty.
- Exactly one FIFO write per four-phase cycle, whatever the duration of the data or null phase.

## Timing
- Reset values: `ack_o`=0, `out_valid`=0, `err`=0, count=0, FSM=WAIT_DATA, synchroniser flops=0.
- Latency, last rail rising to `ack_o` rising: 3 `clk` edges (2 synchroniser + 1 FSM).
- `out_valid` rises on the same edge as `ack_o` when the FIFO was empty.
- Latency, last rail falling to `ack_o` falling: 3 edges.
- Minimum four-phase period is 6 `clk` cycles plus sender delay.
- Reset mid-operation:
  - FIFO contents are discarded and `ack_o` drops on the reset edge.
  - If the bus is still complete after reset, it is captured as a new token 3 edges after `rst_n` rises.
  - Preventing that duplicate is the sender's responsibility: sender and receiver share the reset.
- Pop while full: count goes DEPTH→DEPTH-1. A stalled token is captured on the following edge.

## Configuration
- `FP_RX_ERR_EN` defined:
  - Any bit of `in_s` == 2'b11 while in WAIT_DATA sets `err`=1 on the next edge. It stays set until reset.
  - The word is still captured; the illegal bit decodes to 1.
- `FP_RX_ERR_EN` undefined:
  - `err` is tied to 0 and no detection logic is built.
  - The port is kept so the interface does not change.

## Structure
- Package `fp_pkg` holds:
  - Rail code constants `FP_NULL`, `FP_F`, `FP_T`, `FP_ILL`.
  - FSM typedef `fp_rx_state_t` {WAIT_DATA, WAIT_NULL}.
  - The `RAIL_NUM`=2 constant.
- Sub-module `sync_2ff` (parameter `WIDTH`): a plain two-flop synchroniser with synchronous active-low reset. It is instantiated once over the flattened `WIDTH*RAIL_NUM` rails.
- The FIFO stays inline.

## Test plan
- Reset, then drive bus 0x5A (bits 01/10 per code), then null with `out_ready`=1 → `ack_o` rises 3 edges after data and falls 3 edges after null; a single `out_data`=0x5A pop.
- Skewed arrival (bits go valid one per cycle over 8 cycles) → no capture and `ack_o`=0 until the last bit. Then exactly one word, with the correct value.
- `out_ready`=0, send 5 tokens 0x01..0x05 → first 4 are accepted. The 5th holds `ack_o`=0 with `out_valid`=1. Pulsing `out_ready` once captures 0x05 on the following edge. The drain order is 0x01..0x05.
- Assert `rst_n`=0 while in WAIT_NULL with 2 words queued → `ack_o`=0, `out_valid`=0 on that edge. After release with the bus null, no word appears.
- With `FP_RX_ERR_EN`, drive bit 3 = 2'b11 → `err`=1 after 3 edges and stays 1 through further legal tokens until reset. Without the macro, `err` is always 0.
